instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 13'd0, first word address fetched after reset.
REQ-002 Parameter ADDR_W, default 13, word-address width toward instruction memory.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_addr  output  ADDR_W  word address to instruction memory; combinational from state and inputs.
REQ-006 imem_data  input  32  instruction memory read data; valid one cycle after imem_addr is presented.
REQ-007 fetch_en  input  1  run request; low requests halt.
REQ-008 stall  input  1  decode cannot accept; hold the current instruction.
REQ-009 branch_taken  input  1  redirect request from a later stage.
REQ-010 branch_target  input  ADDR_W  redirect address.
REQ-011 if_instr  output  32  fetched instruction; 32'h0 (NOP) when if_valid is low.
REQ-012 if_pc  output  ADDR_W  word address of if_instr.
REQ-013 if_valid  output  1  if_instr/if_pc are valid for decode this cycle.
REQ-014 fetch_count  output  16  count of instructions delivered (if_valid & ~stall).

Function
REQ-015 FSM states: BOOT, RUN, HALT.
REQ-016 Register pc holds the address whose data is on imem_data in RUN.
REQ-017 BOOT: imem_addr = RESET_PC and if_valid = 0; next state RUN with pc <= RESET_PC, or HALT if fetch_en low.
REQ-018 RUN outputs: if_instr = imem_data, if_pc = pc, and if_valid = 1, except as REQ-022 requires.
REQ-019 RUN, no stall, no branch: imem_addr = pc+1, pc <= pc+1 (mod 2^ADDR_W; 8191 wraps to 0).
REQ-020 RUN, stall, no branch: imem_addr = pc, pc holds, so if_instr/if_pc stay stable next cycle.
REQ-021 branch_taken has priority over stall and fetch_en: imem_addr = branch_target, pc <= branch_target, state RUN.
REQ-022 In a branch_taken cycle, if_valid = 0 (wrong-path squash), so no delivery is counted.
REQ-023 The first instruction at the target appears with if_valid = 1 in the following cycle; no extra bubble.
REQ-024 RUN with fetch_en low and no stall: deliver the current instruction, then go to HALT with pc <= pc+1.
REQ-025 RUN with fetch_en low and stall: remain in RUN until stall drops.
REQ-026 HALT: if_valid = 0 and imem_addr = pc.
REQ-027 HALT with fetch_en high: go to RUN; the instruction at pc is valid that cycle, since the address has been held.
REQ-028 fetch_count increments by 1 each cycle with if_valid & ~stall, and wraps at 16'hFFFF -> 0.
REQ-029 Stall in a non-valid cycle has no effect besides REQ-020/REQ-026 address hold.

Reset
REQ-030 While rst_n is low: state = BOOT, pc = RESET_PC, if_valid = 0, if_instr = 0, if_pc = RESET_PC, fetch_count = 0, imem_addr = RESET_PC.
REQ-031 Reset assertion mid-RUN takes effect immediately, without waiting for a clock edge.
REQ-032 After rst_n deasserts, the first posedge performs the BOOT step; the first valid instruction appears one cycle later.

Structure
REQ-033 Shared package MusaPkg holds ADDR_W, INSTR_W = 32, NOP = 32'h0, and the fetch-state enum.
REQ-034 One sub-module, FetchPcSel, computes next-pc/imem_addr combinationally (branch > stall > halt > increment).
REQ-035 All registers live in instruction_fetch.

Verification
REQ-036 Reset release, fetch_en = 1, memory word[i] = i+100 -> BOOT one cycle, then if_pc 0,1,2,3 with if_instr 100,101,102,103 on consecutive cycles.
REQ-037 Stall held 3 cycles at pc = 5 -> if_pc = 5, if_instr = 105 stable for 4 cycles, fetch_count advances by 1 only.
REQ-038 branch_taken with target 20 asserted together with stall at pc = 7 -> that cycle if_valid = 0; next cycle if_pc = 20, if_instr = 120.
REQ-039 pc = 8191 running -> next if_pc = 0; fetch_count wraps from 16'hFFFF to 0 on the next delivery.
REQ-040 fetch_en low at pc = 3 -> pc 3 delivered, then HALT with if_valid = 0; fetch_en high again -> if_pc = 4 valid on the first RUN cycle.
REQ-041 rst_n pulsed low mid-RUN, between clock edges -> if_valid = 0 and imem_addr = RESET_PC immediately; sequence restarts per REQ-036.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch front end: widths, the NOP encoding and the fetch FSM states.
package MusaPkg;

  localparam int ADDR_W  = 13;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_pc_sel.sv
// Next-pc select. The chosen address is presented to memory and also becomes the next pc,
// so memory data always lines up with the registered pc one cycle later.
module FetchPcSel
  import MusaPkg::*;
#(
  parameter int AW = MusaPkg::ADDR_W
) (
  input  fetch_state_e  state_i,
  input  logic [AW-1:0] pc_i,
  input  logic [AW-1:0] reset_pc_i,
  input  logic          branch_taken_i,
  input  logic [AW-1:0] branch_target_i,
  input  logic          stall_i,
  output logic [AW-1:0] next_pc_o
);

  // Priority: branch > stall > halt hold > increment; BOOT ignores redirects.
  always_comb begin
    next_pc_o = pc_i + AW'(1);
    case (state_i)
      ST_BOOT: next_pc_o = reset_pc_i;
      ST_HALT: next_pc_o = branch_taken_i ? branch_target_i : pc_i;
      ST_RUN: begin
        if (branch_taken_i)  next_pc_o = branch_target_i;
        else if (stall_i)    next_pc_o = pc_i;
        else                 next_pc_o = pc_i + AW'(1);
      end
      default: next_pc_o = reset_pc_i;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: sequential fetch from a one-cycle-latency memory with stall hold,
// branch redirect with wrong-path squash, halt/resume, and a delivered-instruction counter.
//
// state | meaning
// BOOT  | after reset; presenting RESET_PC, nothing valid yet
// RUN   | pc's word is on imem_data and offered to decode
// HALT  | fetch stopped; pc held on imem_addr so resume needs no bubble
module instruction_fetch
  import MusaPkg::*;
#(
  parameter int                ADDR_W   = MusaPkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [ADDR_W-1:0]           imem_addr,
  input  logic [MusaPkg::INSTR_W-1:0] imem_data,
  input  logic                        fetch_en,
  input  logic                        stall,
  input  logic                        branch_taken,
  input  logic [ADDR_W-1:0]           branch_target,
  output logic [MusaPkg::INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]           if_pc,
  output logic                        if_valid,
  output logic [15:0]                 fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       fetch_count_q;
  logic              deliver;

  FetchPcSel #(.AW(ADDR_W)) u_pc_sel (
    .state_i         (state_q),
    .pc_i            (pc_q),
    .reset_pc_i      (RESET_PC),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .stall_i         (stall),
    .next_pc_o       (pc_d)
  );

  always_comb begin
    state_d  = state_q;
    if_valid = 1'b0;
    case (state_q)
      ST_BOOT: state_d = fetch_en ? ST_RUN : ST_HALT;
      ST_RUN: begin
        if (!branch_taken) begin
          if_valid = 1'b1;
          // A stalled instruction must still be handed over before halting.
          if (!fetch_en && !stall) state_d = ST_HALT;
        end
      end
      ST_HALT: if (branch_taken || fetch_en) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  assign imem_addr   = pc_d;
  assign if_instr    = if_valid ? imem_data : NOP;
  assign if_pc       = pc_q;
  assign deliver     = if_valid & ~stall;
  assign fetch_count = fetch_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (deliver) fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a one-cycle-latency memory model (word[i] = i + 100).
module tb_instruction_fetch;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          fetch_en;
  logic          stall;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic [31:0]   if_instr;
  logic [AW-1:0] if_pc;
  logic          if_valid;
  logic [15:0]   fetch_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= 32'(imem_addr) + 32'd100;

  instruction_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .fetch_en      (fetch_en),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .fetch_count   (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_run(input string tag, input int pc, input int cnt);
    chk({tag, "_valid"}, 32'(if_valid), 32'd1);
    chk({tag, "_pc"}, 32'(if_pc), 32'(pc));
    chk({tag, "_instr"}, if_instr, 32'(pc) + 32'd100);
    chk({tag, "_count"}, 32'(fetch_count), 32'(cnt));
  endtask

  task automatic chk_idle(input string tag, input int addr, input int cnt);
    chk({tag, "_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_instr"}, if_instr, 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'(addr));
    chk({tag, "_count"}, 32'(fetch_count), 32'(cnt));
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    repeat (3) tick();
    chk_idle("rst", 0, 0);
    chk("rst_pc", 32'(if_pc), 32'd0);

    rst_n = 1'b1;
    #1;
    chk_idle("boot", 0, 0);

    tick(); chk_run("run0", 0, 0); chk("run0_addr", 32'(imem_addr), 32'd1);
    tick(); chk_run("run1", 1, 1);
    tick(); chk_run("run2", 2, 2);
    tick();
    fetch_en = 1'b0; #1;
    chk_run("run3_halt_req", 3, 3);
    chk("run3_addr", 32'(imem_addr), 32'd4);
    tick(); chk_idle("halt_a", 4, 4); chk("halt_a_pc", 32'(if_pc), 32'd4);
    tick(); chk_idle("halt_b", 4, 4);
    fetch_en = 1'b1; #1;
    chk_idle("halt_resume", 4, 4);
    tick(); chk_run("resume4", 4, 4);
    tick();
    stall = 1'b1; #1;
    chk_run("stall1", 5, 5); chk("stall1_addr", 32'(imem_addr), 32'd5);
    tick(); chk_run("stall2", 5, 5);
    tick(); chk_run("stall3", 5, 5);
    tick();
    stall = 1'b0; #1;
    chk_run("stall4", 5, 5);
    tick(); chk_run("after_stall", 6, 6);
    tick();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 13'd20; #1;
    chk_idle("squash", 20, 7);
    tick();
    stall = 1'b0; branch_taken = 1'b0; #1;
    chk_run("target20", 20, 7);
    tick();
    branch_taken = 1'b1; branch_target = 13'd8190; #1;
    chk_idle("squash2", 8190, 8);
    tick();
    branch_taken = 1'b0; #1;
    chk_run("pc8190", 8190, 8);
    tick(); chk_run("pc8191", 8191, 9);
    tick(); chk_run("pc_wrap", 0, 10); chk("wrap_addr", 32'(imem_addr), 32'd1);

    repeat (65525) tick();
    chk_run("cnt_ffff", 8181, 16'hFFFF);
    tick(); chk_run("cnt_wrap", 8182, 0);

    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst", 0, 0);
    chk("async_rst_pc", 32'(if_pc), 32'd0);
    #2;
    rst_n = 1'b1;
    tick(); chk_run("restart0", 0, 0);
    tick(); chk_run("restart1", 1, 1);
    tick(); chk_run("restart2", 2, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
